// File: rtl/clock_pkg.sv
// Shared edit-mode encoding and default timing constants for the clock
// set/increment controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_t;

  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int HOLD_MS_DEF     = 600;
  localparam int REPEAT_MS_DEF   = 150;
  localparam int BLINK_MS_DEF    = 500;
  localparam int TIMEOUT_S_DEF   = 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus tick-sampled debouncer for one raw button.
// 'toggled' pulses for one clk in the same cycle 'level' takes its new value.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic btn,
  output logic level,
  output logic toggled
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level   <= 1'b0;
      toggled <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      toggled <= 1'b0;
      // Only disagreeing samples advance; one agreeing sample restarts the run.
      if (tick_ms) begin
        if (sync_q[1] != level) begin
          if (cnt_q == CNT_LAST) begin
            level   <= sync_q[1];
            toggled <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/set_ctrl.sv
// Clock-setting controller: set button cycles the edit mode, inc button
// advances hours/minutes with auto-repeat, digits blink while editing.
//
//   state          | meaning
//   MODE_RUN       | normal timekeeping, no edits, blink off
//   MODE_SET_HOUR  | inc advances hour digits, hour digits blink
//   MODE_SET_MIN   | inc advances minute digits, minute digits blink
module set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS     = HOLD_MS_DEF,
  parameter int REPEAT_MS   = REPEAT_MS_DEF,
  parameter int BLINK_MS    = BLINK_MS_DEF,
  parameter int TIMEOUT_S   = TIMEOUT_S_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       sec_tick,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [1:0] mode,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blink
);

  localparam int RW = $clog2(max2(HOLD_MS, REPEAT_MS) + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_MS - 1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);

  mode_t         mode_q, mode_nxt;
  logic          set_level, set_edge, inc_level, inc_edge;
  logic          edit, set_fall, inc_rise, any_edge;
  logic          timeout_hit, rpt_fire, mode_chg, pulse;
  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_armed_q;
  logic [BW-1:0] blink_cnt_q;
  logic [TW-1:0] to_cnt_q;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_set (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .btn(btn_set),
    .level(set_level), .toggled(set_edge)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .btn(btn_inc),
    .level(inc_level), .toggled(inc_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= MODE_RUN;
    else     mode_q <= mode_nxt;
  end

  always_comb begin
    edit        = (mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN);
    set_fall    = set_edge && !set_level;
    inc_rise    = inc_edge && inc_level;
    any_edge    = set_edge || inc_edge;
    timeout_hit = edit && sec_tick && !any_edge && (to_cnt_q == TO_LAST);
    rpt_fire    = edit && inc_level && tick_ms &&
                  (rpt_cnt_q == (rpt_armed_q ? RPT_LAST : HOLD_LAST));
    mode_nxt    = mode_q;
    case (mode_q)
      MODE_RUN:      if (set_fall) mode_nxt = MODE_SET_HOUR;
      MODE_SET_HOUR: if (set_fall) mode_nxt = MODE_SET_MIN;
                     else if (timeout_hit) mode_nxt = MODE_RUN;
      MODE_SET_MIN:  if (set_fall || timeout_hit) mode_nxt = MODE_RUN;
      default:       mode_nxt = MODE_RUN;
    endcase
    mode_chg = (mode_nxt != mode_q);
    // A mode change in the same cycle swallows the increment.
    pulse    = edit && !mode_chg && (inc_rise || rpt_fire);
  end

  assign mode = edit ? mode_q : MODE_RUN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_hour    <= 1'b0;
      inc_min     <= 1'b0;
      clr_sec     <= 1'b0;
      blink       <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      blink_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      inc_hour <= pulse && (mode_q == MODE_SET_HOUR);
      inc_min  <= pulse && (mode_q == MODE_SET_MIN);
      clr_sec  <= pulse;

      if (!edit || !inc_level || mode_chg) begin
        rpt_cnt_q   <= '0;
        rpt_armed_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_q   <= '0;
        rpt_armed_q <= 1'b1;
      end else if (tick_ms) begin
        rpt_cnt_q <= rpt_cnt_q + 1'b1;
      end

      if (!edit || any_edge || mode_chg) to_cnt_q <= '0;
      else if (sec_tick)                 to_cnt_q <= to_cnt_q + 1'b1;

      // Each increment relights the digits and restarts the blink phase.
      if (!edit || mode_chg || pulse) begin
        blink       <= 1'b0;
        blink_cnt_q <= '0;
      end else if (tick_ms) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink       <= ~blink;
          blink_cnt_q <= '0;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_set_ctrl.sv
// Directed bench for set_ctrl with default timing; increment pulses are
// checked against a queue of expected (kind, millisecond) entries.
module tb_set_ctrl;
  import clock_pkg::*;

  localparam int CLK_PER_MS = 8;

  logic       clk = 1'b0, rst = 1'b1, tick_ms = 1'b0, sec_tick = 1'b0;
  logic       btn_set = 1'b0, btn_inc = 1'b0;
  logic [1:0] mode;
  logic       inc_hour, inc_min, clr_sec, blink;

  int ms_cnt = 0, div = 0, checks = 0, errors = 0, last_pulse_ms = 0;

  typedef struct {
    logic is_min;
    int   ms;
  } exp_t;
  exp_t sb[$];

  set_ctrl dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .sec_tick(sec_tick),
    .btn_set(btn_set), .btn_inc(btn_inc), .mode(mode),
    .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec), .blink(blink)
  );

  always #5 clk = ~clk;

  // tick_ms strobe and its millisecond stamp change 3 ns after a rising edge.
  always begin
    @(posedge clk);
    #3;
    if (div == CLK_PER_MS - 1) begin
      div = 0;
      tick_ms = 1'b1;
      ms_cnt++;
    end else begin
      div++;
      tick_ms = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ms(input int n);
    int t;
    t = ms_cnt + n;
    while (ms_cnt < t) @(negedge clk);
  endtask

  task automatic press_set();
    btn_set = 1'b1;
    wait_ms(30);
    btn_set = 1'b0;
    wait_ms(30);
  endtask

  task automatic expect_pulse(input logic is_min, input int ms);
    exp_t e;
    e.is_min = is_min;
    e.ms = ms;
    sb.push_back(e);
  endtask

  task automatic wait_blink_high(output int n);
    n = 0;
    while (blink !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int p, n;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (inc_hour || inc_min || clr_sec) begin
            chk("clr_sec_eq_or", clr_sec, inc_hour | inc_min);
            chk("inc_onehot", inc_hour & inc_min, 0);
            chk("blink_at_pulse", blink, 0);
            checks++;
            assert (sb.size() > 0) else begin
              errors++;
              $error("FAIL unexpected_pulse: got inc_hour=%b inc_min=%b at %0d ms, expected none",
                     inc_hour, inc_min, ms_cnt);
            end
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("pulse_kind_is_min", inc_min, e.is_min);
              chk("pulse_ms", ms_cnt, e.ms);
            end
            last_pulse_ms = ms_cnt;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mode", mode, MODE_RUN);
    chk("rst_inc_hour", inc_hour, 0);
    chk("rst_inc_min", inc_min, 0);
    chk("rst_clr_sec", clr_sec, 0);
    chk("rst_blink", blink, 0);
    rst = 1'b0;
    wait_ms(5);

    // Set button walks RUN -> SET_HOUR -> SET_MIN -> RUN
    press_set();
    chk("mode_after_set1", mode, MODE_SET_HOUR);
    press_set();
    chk("mode_after_set2", mode, MODE_SET_MIN);
    press_set();
    chk("mode_after_set3", mode, MODE_RUN);
    chk("blink_in_run", blink, 0);

    // Bouncy inc press in SET_HOUR: one pulse 20 ms after it settles
    press_set();
    chk("mode_hour", mode, MODE_SET_HOUR);
    for (int i = 0; i < 5; i++) begin
      btn_inc = 1'b1;
      wait_ms(1);
      btn_inc = 1'b0;
      wait_ms(1);
    end
    btn_inc = 1'b1;
    p = ms_cnt;
    expect_pulse(1'b0, p + 20);
    wait_ms(50);
    btn_inc = 1'b0;
    wait_ms(40);
    chk("bounce_sb_empty", sb.size(), 0);

    // Held inc in SET_MIN: first pulse, then hold delay, then repeat period
    press_set();
    chk("mode_min", mode, MODE_SET_MIN);
    btn_inc = 1'b1;
    p = ms_cnt;
    expect_pulse(1'b1, p + 20);
    expect_pulse(1'b1, p + 620);
    expect_pulse(1'b1, p + 770);
    expect_pulse(1'b1, p + 920);
    wait_ms(1000);
    btn_inc = 1'b0;
    wait_ms(40);
    chk("repeat_sb_empty", sb.size(), 0);

    // Inc in the middle of the blink-high phase relights and rephases blink
    wait_blink_high(n);
    chk("blink_high_seen", blink, 1);
    wait_ms(230);
    chk("blink_high_before_inc", blink, 1);
    btn_inc = 1'b1;
    expect_pulse(1'b1, ms_cnt + 20);
    wait_ms(30);
    btn_inc = 1'b0;
    wait_blink_high(n);
    chk("blink_rephase_seen", blink, 1);
    chk("blink_rephase_ms", ms_cnt - last_pulse_ms, 500);

    // Timeout back to RUN after 10 seconds without activity
    press_set();
    chk("mode_run_again", mode, MODE_RUN);
    press_set();
    chk("mode_hour_again", mode, MODE_SET_HOUR);
    for (int i = 1; i <= 10; i++) begin
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
      chk($sformatf("timeout_sec%0d", i), mode, (i < 10) ? MODE_SET_HOUR : MODE_RUN);
      repeat (3) @(negedge clk);
    end
    chk("timeout_blink", blink, 0);

    // Reset in the middle of auto-repeat, buttons held through it
    press_set();
    chk("mode_hour_rst", mode, MODE_SET_HOUR);
    btn_inc = 1'b1;
    p = ms_cnt;
    expect_pulse(1'b0, p + 20);
    expect_pulse(1'b0, p + 620);
    wait_ms(700);
    btn_set = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_async_mode", mode, MODE_RUN);
    chk("rst_async_inc_hour", inc_hour, 0);
    chk("rst_async_clr_sec", clr_sec, 0);
    chk("rst_async_blink", blink, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_ms(10);
    btn_set = 1'b0;
    wait_ms(40);
    chk("set_held_through_rst", mode, MODE_RUN);
    btn_inc = 1'b0;
    wait_ms(40);
    press_set();
    chk("mode_after_rst_press", mode, MODE_SET_HOUR);

    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/set_ctrl.md
SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20, meaning consecutive tick_ms samples required to accept a button level change.
REQ-002 SHALL have parameter HOLD_MS, default 600, meaning tick_ms count of a held inc button before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_MS, default 150, meaning tick_ms period between auto-repeat increments.
REQ-004 SHALL have parameter BLINK_MS, default 500, meaning tick_ms half-period of the blink output.
REQ-005 SHALL have parameter TIMEOUT_S, default 10, meaning sec_tick count without button activity before returning to RUN.
REQ-006 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port tick_ms  input  1  one-clk strobe, once per millisecond.
REQ-009 SHALL have port sec_tick  input  1  one-clk strobe, once per second.
REQ-010 SHALL have port btn_set  input  1  raw set button, asynchronous, 1 = pressed.
REQ-011 SHALL have port btn_inc  input  1  raw increment button, asynchronous, 1 = pressed.
REQ-012 SHALL have port mode  output  2  current edit mode (RUN=0, SET_HOUR=1, SET_MIN=2).
REQ-013 SHALL have port inc_hour  output  1  one-clk pulse: advance hour digits.
REQ-014 SHALL have port inc_min  output  1  one-clk pulse: advance minute digits.
REQ-015 SHALL have port clr_sec  output  1  one-clk pulse: zero seconds and second divider; asserted with every inc_hour/inc_min.
REQ-016 SHALL have port blink  output  1  1 = blank the digits being edited.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level flips only after the synchronized level differs from it on DEBOUNCE_MS consecutive tick_ms strobes; any agreeing sample restarts the count.
REQ-018 Debounced set falling edge SHALL advance mode RUN->SET_HOUR->SET_MIN->RUN, visible the clk after the edge is detected; value 3 is unreachable and SHALL decode as RUN.
REQ-019 Debounced inc rising edge SHALL produce one pulse: inc_hour in SET_HOUR, inc_min in SET_MIN, none in RUN.
REQ-020 While debounced inc stays high in SET_HOUR/SET_MIN, a tick_ms counter SHALL fire an extra pulse at HOLD_MS ticks after the rising edge, then every REPEAT_MS ticks; the counter clears on inc release and on any mode change.
REQ-021 At most one of inc_hour/inc_min SHALL be high in any cycle; clr_sec SHALL equal their OR.
REQ-022 Set falling edge and an inc pulse in the same cycle: mode change wins, inc pulse suppressed, repeat counter cleared.
REQ-023 Timeout counter SHALL count sec_tick in SET_HOUR/SET_MIN, clear on any debounced edge of either button and in RUN; reaching TIMEOUT_S forces mode to RUN next clk.
REQ-024 Timeout and set falling edge in the same cycle: set edge wins.
REQ-025 blink SHALL be 0 in RUN; in edit modes it toggles every BLINK_MS tick_ms strobes, starting at 0 on mode entry.
REQ-026 Every inc pulse SHALL force blink to 0 and restart its phase counter, so digits stay lit during editing.
REQ-027 Counters SHALL saturate-free wrap only by explicit clear; widths sized by $clog2 of parameter+1.

Reset
REQ-028 rst SHALL asynchronously set mode=RUN, inc_hour=inc_min=clr_sec=blink=0, synchronizer flops and debounced levels 0, all counters 0.
REQ-029 A button held through reset deassertion SHALL be accepted as a new press only after DEBOUNCE_MS ticks.

Structure
REQ-030 Mode encoding enum and parameter defaults SHALL live in shared package clock_pkg.
REQ-031 Synchronizer+debouncer SHALL be sub-module btn_debounce, instantiated twice.

Verification
REQ-032 Set pressed 30 ms then released, three times -> mode 1, 2, 0 after each release.
REQ-033 Mode 1, inc bounce of 5 ms glitches then held 50 ms -> exactly one inc_hour with clr_sec, 20 ticks after stable level.
REQ-034 Mode 2, inc held 1000 ms -> inc_min pulses at press+20, +620, +770, +920 ms (4 total).
REQ-035 Mode 1, no buttons, 10 sec_tick -> mode 0 on the clk after the 10th; blink 0.
REQ-036 Mode 2, inc pulse at mid blink-high phase -> blink 0 same cycle, next toggle 500 ticks later.
REQ-037 rst asserted mid auto-repeat -> immediate mode 0, no pulses; held button needs 20 ticks after release of rst.
